adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit adder datapath among NUM_REQ requesters.
- Round-robin arbitration, registered result with requester ID tag, and output backpressure.
- Optional per-requester lock that chains the carry across consecutive grants, giving multi-word (multi-precision) addition.
- Sits between several client blocks and a single adder slice, replacing per-client adders.

Parameters:
- WIDTH, 4, operand and sum width per transaction.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ).
- USE_FULL_ADDER, 1, 1 = cin / chained carry feeds the adder; 0 = carry-in forced to 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request per requester; held with operands until granted.
- lock  in  NUM_REQ  per requester: keep the grant after this transaction and chain the carry.
- a_flat  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_flat  in  NUM_REQ*WIDTH  operand B, same packing as a_flat.
- cin  in  NUM_REQ  carry-in per requester; used only on the first or unlocked transaction.
- gnt  out  NUM_REQ  one-hot grant; combinational; marks the accept cycle.
- rsp_valid  out  1  result register holds valid data.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_id  out  ID_W  index of the requester that produced the result.

Behaviour:
- Reset values: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rr pointer=0, state=IDLE, carry_q=0. gnt=0 while rst is high.
- Issue condition: issue_ok = !rsp_valid || rsp_ready. When issue_ok=0, gnt=0 and all result outputs hold.
- Arbitration in IDLE: grant the first requester with req=1, searching from the rr pointer upward and wrapping modulo NUM_REQ. At most one gnt bit is high.
- Accept cycle: when gnt[i]=1, on the next edge:
  - rsp_valid<=1.
  - {rsp_cout,rsp_sum}<=a_i+b_i+cin_eff, where cin_eff = (USE_FULL_ADDER ? (state==LOCKED ? carry_q : cin[i]) : 0).
  - rsp_id<=i.
  - carry_q<=adder cout.
- Latency: exactly 1 cycle from grant to rsp_valid. Throughput is 1 transaction per cycle while rsp_ready=1.
- No grant while issue_ok=1: if rsp_ready=1, rsp_valid<=0.
- Requester protocol: a requester treats gnt[i] as acceptance and may change operands or drop req the next cycle. Dropping req before a grant is legal; the arbiter has no memory of it.
- State machine, two states IDLE and LOCKED, with lock_id register:
  - IDLE, grant i with lock[i]=1 -> LOCKED, lock_id<=i.
  - IDLE, grant i with lock[i]=0 -> stay IDLE, pointer<=(i+1) mod NUM_REQ.
  - LOCKED: only req[lock_id] can be granted. Other requests wait even when the lock holder is idle.
  - LOCKED, grant with lock[lock_id]=1 -> stay LOCKED (chain continues).
  - LOCKED, grant with lock[lock_id]=0 -> IDLE (final word), pointer<=(lock_id+1) mod NUM_REQ.
  - The pointer does not advance during LOCKED.
- Boundary conditions:
  - Pointer wraps from NUM_REQ-1 to 0.
  - Backpressure during LOCKED holds the state and carry_q.
  - rst asserted mid-chain: state returns to IDLE and carry_q clears. An in-flight result is dropped (rsp_valid=0).
  - rsp_ready=1 and a new grant in the same cycle: the new result replaces the old one with no bubble.
  - Arithmetic width is WIDTH+1 bits, no saturation. Overflow appears only in rsp_cout.

Decomposition:
- Shared package:
  - arb_state_t enum {IDLE, LOCKED}.
  - clog2 helper for ID_W.
  - Packing macro or function for the [i*WIDTH +: WIDTH] slice.
- Sub-module adder_slice: combinational WIDTH-bit add with cin and cout. One instance, selected operands muxed in. The result register lives in adder_share_arbiter.

Test Plan:
- All tests use WIDTH=4.
- Single request: req=0001, a0=3, b0=4, cin0=1, rsp_ready=1 -> gnt=0001 in the same cycle; next cycle rsp_valid=1, sum=8, cout=0, id=0.
- Round robin: req=1111 held, rsp_ready=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001; rsp_id 0,1,2,3,0.
- Backpressure:
  - Result pending and rsp_ready=0 for 3 cycles -> gnt=0 and outputs stable.
  - rsp_ready=1 -> next grant follows the pointer order.
- Carry chain (8-bit 0x0F+0x01): req1 lock=1 a=F b=1 cin=0 gives sum=0 cout=1; then req1 lock=0 a=0 b=0 gives sum=1 cout=0. req0 and req2 stay high and are not granted until the chain ends; the next grant goes to req2.
- Reset mid-chain: rst during LOCKED -> all outputs 0, state IDLE; after release with req=1111, the first grant is 0001.
- USE_FULL_ADDER=0: a=F b=F cin=1 -> sum=E cout=1 (cin ignored); chained carry is also ignored.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the shared-adder arbiter.
package adder_share_arbiter_pkg;

    // IDLE arbitrates round-robin; LOCKED keeps the grant with one requester
    // so its carry can chain into the next word.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Ceiling log2, used to size requester indices.
    function automatic int clog2_f(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

    // Low bit of requester idx's operand inside a flattened operand bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational WIDTH-bit adder with carry-in and carry-out.
module adder_slice #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // One extra bit keeps the carry-out; no saturation.
    logic [WIDTH:0] w_full;

    assign w_full          = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign {o_cout, o_sum} = w_full;

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one adder among NUM_REQ requesters: round-robin grant, registered
// tagged result with backpressure, and per-requester lock for carry chaining.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = clog2_f(NUM_REQ),
    parameter int USE_FULL_ADDER = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*WIDTH-1:0] a_flat,
    input  logic [NUM_REQ*WIDTH-1:0] b_flat,
    input  logic [NUM_REQ-1:0]       cin,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id
);

    // Arbitration state
    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [ID_W-1:0]   r_lock_id;
    logic [ID_W-1:0]   w_lock_id_nxt;
    logic              r_carry;

    // Result register
    logic              r_valid;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic [ID_W-1:0]   r_id;

    // Grant and datapath
    logic              w_issue_ok;
    logic [NUM_REQ-1:0] w_gnt;
    logic              w_any_gnt;
    logic [ID_W-1:0]   w_sel;
    logic [ID_W-1:0]   w_cand;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic              w_cin_sel;
    logic              w_cin_eff;
    logic [WIDTH-1:0]  w_sum;
    logic              w_cout;

    // Successor of a requester index, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] x);
        return ID_W'((int'(x) + 1) % NUM_REQ);
    endfunction

    // A new result may be issued when the register is empty or being drained.
    assign w_issue_ok = !r_valid || rsp_ready;
    assign w_any_gnt  = |w_gnt;

    // Grant selection: lock owner only while LOCKED, else first request from the pointer.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_gnt  = '0;
        w_sel  = '0;
        w_cand = '0;
        if (!rst && w_issue_ok) begin
            if (r_state == LOCKED) begin
                if (req[r_lock_id]) begin
                    w_gnt[r_lock_id] = 1'b1;
                    w_sel            = r_lock_id;
                end
            end else begin
                // Scan farthest offset first so the nearest request from the pointer wins.
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
                    if (req[w_cand]) begin
                        w_sel = w_cand;
                    end
                end
                if (|req) begin
                    w_gnt[w_sel] = 1'b1;
                end
            end
        end
    end

    // Steer the granted requester's operands and carry-in to the shared adder.
    always_comb begin
        w_a       = '0;
        w_b       = '0;
        w_cin_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == ID_W'(i)) begin
                w_a       = a_flat[slice_lo(i, WIDTH) +: WIDTH];
                w_b       = b_flat[slice_lo(i, WIDTH) +: WIDTH];
                w_cin_sel = cin[i];
            end
        end
        if (USE_FULL_ADDER != 0) begin
            w_cin_eff = (r_state == LOCKED) ? r_carry : w_cin_sel;
        end else begin
            w_cin_eff = 1'b0;
        end
    end

    adder_slice #(
        .WIDTH (WIDTH)
    ) u_adder_slice (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (w_cin_eff),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Next-state logic: enter/leave LOCKED on accepted words, advance pointer only on unlocked grants.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_lock_id_nxt = r_lock_id;
        if (w_any_gnt) begin
            case (r_state)
                IDLE: begin
                    if (lock[w_sel]) begin
                        w_state_nxt   = LOCKED;
                        w_lock_id_nxt = w_sel;
                    end else begin
                        w_ptr_nxt = next_idx(w_sel);
                    end
                end
                LOCKED: begin
                    if (!lock[r_lock_id]) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = next_idx(r_lock_id);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State, pointer and lock owner registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    // Result register and chained carry: load on grant, clear valid when drained with nothing new.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= '0;
            r_carry <= 1'b0;
        end else if (w_any_gnt) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_id    <= w_sel;
            r_carry <= w_cout;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign gnt       = w_gnt;
    assign rsp_valid = r_valid;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;

endmodule
